acc_cell: RTL and testbench

- Sequential accumulation primitive; the consumer end of the fixed-point add stream.
- Takes a valid-qualified stream of signed fixed-point words, such as add_res/add_res_val from the adder primitives or systolic-array partial sums.
- Sums groups of acc_len words into one word using the same saturating two's-complement arithmetic as the adder.
- Emits one valid-qualified result per group. Used for partial-sum reduction at the systolic array edge.

---
 rtl/acc_cell.sv | 136 +++++++++++++
 tb/tb_acc_cell.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/acc_cell.sv
// Saturating/wrapping group accumulator for valid-qualified signed fixed-point streams.
// Optional abort input acc_clr is enabled by defining ACC_CELL_CLR_IN_EN.
module acc_cell #(
  parameter int ACC_WORD_WDT = 16,
  parameter int ACC_CNT_WDT  = 8,
  parameter int ACC_SATUR    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
`ifdef ACC_CELL_CLR_IN_EN
  input  logic                    acc_clr,
`endif
  input  logic [ACC_WORD_WDT-1:0] acc_op,
  input  logic                    acc_op_val,
  input  logic [ACC_CNT_WDT-1:0]  acc_len,
  output logic [ACC_WORD_WDT-1:0] acc_res,
  output logic                    acc_res_val,
  output logic                    acc_ovf,
  output logic                    acc_busy
);

  localparam logic signed [ACC_WORD_WDT-1:0] MAXV = {1'b0, {(ACC_WORD_WDT-1){1'b1}}};
  localparam logic signed [ACC_WORD_WDT-1:0] MINV = {1'b1, {(ACC_WORD_WDT-1){1'b0}}};
  localparam logic [ACC_CNT_WDT-1:0]         ONE  = {{(ACC_CNT_WDT-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACCUM} state_t;

  // Returns {overflow, result}; result is clamped when saturation is enabled.
  function automatic logic [ACC_WORD_WDT:0] sat_add(input logic signed [ACC_WORD_WDT-1:0] a,
                                                    input logic signed [ACC_WORD_WDT-1:0] b);
    logic signed [ACC_WORD_WDT-1:0] s;
    logic                           o;
    s = a + b;
    o = (a[ACC_WORD_WDT-1] == b[ACC_WORD_WDT-1]) && (s[ACC_WORD_WDT-1] != a[ACC_WORD_WDT-1]);
    if ((ACC_SATUR != 0) && o) s = a[ACC_WORD_WDT-1] ? MINV : MAXV;
    return {o, s};
  endfunction

  state_t                          state_q, state_d;
  logic signed [ACC_WORD_WDT-1:0]  acc_q, acc_d;
  logic [ACC_CNT_WDT-1:0]          cnt_q, cnt_d;
  logic [ACC_CNT_WDT-1:0]          len_q, len_d;
  logic                            ovf_q, ovf_d;
  logic [ACC_WORD_WDT-1:0]         res_q, res_d;
  logic                            res_val_q, res_val_d;
  logic                            res_ovf_q, res_ovf_d;

  logic signed [ACC_WORD_WDT-1:0]  step_sum;
  logic                            step_ovf;
  logic [ACC_CNT_WDT-1:0]          len_eff;
  logic [ACC_CNT_WDT-1:0]          cnt_inc;
  logic                            clr;

`ifdef ACC_CELL_CLR_IN_EN
  assign clr = acc_clr;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_val_d = 1'b0;
    res_ovf_d = res_ovf_q;
    {step_ovf, step_sum} = sat_add(acc_q, acc_op);
    len_eff   = (acc_len == '0) ? ONE : acc_len;
    cnt_inc   = cnt_q + ONE;

    // Abort wins over a coincident operand; the last emitted result is kept.
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (acc_op_val) begin
      unique case (state_q)
        IDLE: begin
          acc_d = acc_op;
          ovf_d = 1'b0;
          cnt_d = ONE;
          len_d = len_eff;
          if (len_eff == ONE) begin
            res_d     = acc_op;
            res_ovf_d = 1'b0;
            res_val_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          acc_d = step_sum;
          ovf_d = ovf_q | step_ovf;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            res_d     = step_sum;
            res_ovf_d = ovf_q | step_ovf;
            res_val_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_val_q <= 1'b0;
      res_ovf_q <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_val_q <= res_val_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign acc_res     = res_q;
  assign acc_res_val = res_val_q;
  assign acc_ovf     = res_ovf_q;
  assign acc_busy    = (state_q == ACCUM);

endmodule

// File: tb/tb_acc_cell.sv
// Directed table-driven bench for acc_cell (Q8.8, saturating) plus a wrapping instance.
module tb_acc_cell;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [15:0] acc_op;
  logic        acc_op_val;
  logic [7:0]  acc_len;
`ifdef ACC_CELL_CLR_IN_EN
  logic        acc_clr = 1'b0;
`endif
  logic [15:0] res_s, res_w;
  logic        rv_s, rv_w, ovf_s, ovf_w, busy_s, busy_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acc_cell #(.ACC_WORD_WDT(16), .ACC_CNT_WDT(8), .ACC_SATUR(1)) dut_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en),
`ifdef ACC_CELL_CLR_IN_EN
    .acc_clr(acc_clr),
`endif
    .acc_op(acc_op), .acc_op_val(acc_op_val), .acc_len(acc_len),
    .acc_res(res_s), .acc_res_val(rv_s), .acc_ovf(ovf_s), .acc_busy(busy_s));

  acc_cell #(.ACC_WORD_WDT(16), .ACC_CNT_WDT(8), .ACC_SATUR(0)) dut_wrap (
    .clk(clk), .rst(rst), .clk_en(clk_en),
`ifdef ACC_CELL_CLR_IN_EN
    .acc_clr(acc_clr),
`endif
    .acc_op(acc_op), .acc_op_val(acc_op_val), .acc_len(acc_len),
    .acc_res(res_w), .acc_res_val(rv_w), .acc_ovf(ovf_w), .acc_busy(busy_w));

  typedef struct {
    logic        en;
    logic        val;
    logic [7:0]  len;
    logic [15:0] op;
    logic [15:0] e_res;
    logic        e_rv;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic val, input logic [7:0] len, input logic [15:0] op,
                     input logic [15:0] e_res, input logic e_rv, input logic e_ovf, input logic e_busy);
    vec_t v;
    v.en = en; v.val = val; v.len = len; v.op = op;
    v.e_res = e_res; v.e_rv = e_rv; v.e_ovf = e_ovf; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic val, input logic [7:0] len,
                       input logic [15:0] op);
    rst = r; clk_en = en; acc_op_val = val; acc_len = len; acc_op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] e_res, input logic e_rv,
                           input logic e_ovf, input logic e_busy);
    check({tag, ".res"},  res_s,         e_res);
    check({tag, ".rv"},   {15'd0, rv_s},  {15'd0, e_rv});
    check({tag, ".ovf"},  {15'd0, ovf_s}, {15'd0, e_ovf});
    check({tag, ".busy"}, {15'd0, busy_s}, {15'd0, e_busy});
  endtask

  initial begin
    int          rv_cnt;
    logic [15:0] cap;

    // en val len op      | res    rv ovf busy
    add(1, 1, 4, 16'h0100, 16'h0000, 0, 0, 1);
    add(1, 1, 4, 16'h0200, 16'h0000, 0, 0, 1);
    add(1, 1, 4, 16'hFF00, 16'h0000, 0, 0, 1);
    add(1, 1, 4, 16'h0080, 16'h0280, 1, 0, 0);
    add(1, 0, 4, 16'h0000, 16'h0280, 0, 0, 0);
    add(1, 1, 3, 16'h7000, 16'h0280, 0, 0, 1);
    add(1, 1, 3, 16'h7000, 16'h0280, 0, 0, 1);
    add(1, 1, 3, 16'h8000, 16'hFFFF, 1, 1, 0);
    add(1, 0, 3, 16'h0000, 16'hFFFF, 0, 1, 0);
    add(1, 1, 2, 16'h0010, 16'hFFFF, 0, 1, 1);
    add(1, 0, 2, 16'h0000, 16'hFFFF, 0, 1, 1);
    add(1, 0, 2, 16'h0000, 16'hFFFF, 0, 1, 1);
    add(1, 0, 2, 16'h0000, 16'hFFFF, 0, 1, 1);
    add(1, 1, 2, 16'h0020, 16'h0030, 1, 0, 0);
    add(0, 0, 2, 16'h0000, 16'h0030, 1, 0, 0);
    add(0, 0, 2, 16'h0000, 16'h0030, 1, 0, 0);
    add(1, 0, 2, 16'h0000, 16'h0030, 0, 0, 0);
    add(1, 1, 2, 16'h0001, 16'h0030, 0, 0, 1);
    add(1, 1, 2, 16'h0002, 16'h0003, 1, 0, 0);
    add(1, 1, 2, 16'h0003, 16'h0003, 0, 0, 1);
    add(1, 1, 2, 16'h0004, 16'h0007, 1, 0, 0);
    add(1, 1, 0, 16'h1234, 16'h1234, 1, 0, 0);
    add(1, 1, 1, 16'h8000, 16'h8000, 1, 0, 0);
    add(1, 0, 1, 16'h0000, 16'h8000, 0, 0, 0);
    add(0, 1, 2, 16'h0005, 16'h8000, 0, 0, 0);
    add(1, 1, 2, 16'h8000, 16'h8000, 0, 0, 1);
    add(1, 1, 2, 16'hFFFF, 16'h8000, 1, 1, 0);
    add(1, 1, 3, 16'h0001, 16'h8000, 0, 1, 1);
    add(1, 1, 1, 16'h0001, 16'h8000, 0, 1, 1);
    add(1, 1, 0, 16'h0001, 16'h0003, 1, 0, 0);

    rst = 1'b1; clk_en = 1'b0; acc_op_val = 1'b0; acc_len = '0; acc_op = '0;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    check_out("reset", 16'h0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].en, vecs[i].val, vecs[i].len, vecs[i].op);
      check_out($sformatf("row%0d", i), vecs[i].e_res, vecs[i].e_rv, vecs[i].e_ovf, vecs[i].e_busy);
    end

    // Reset mid-group, with clk_en low, discards the partial sum.
    drive(0, 1, 1, 4, 16'h0005);
    drive(0, 1, 1, 4, 16'h0005);
    check("midgrp.busy", {15'd0, busy_s}, 16'd1);
    drive(1, 0, 0, 4, 16'h0000);
    check_out("after_rst", 16'h0000, 0, 0, 0);
    rv_cnt = 0;
    cap = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, (i < 4), 4, 16'h0001);
      if (rv_s) begin
        rv_cnt++;
        cap = res_s;
      end
    end
    check("rst_grp.count", 16'(rv_cnt), 16'd1);
    check("rst_grp.res", cap, 16'h0004);

    // Same stream into saturating and wrapping instances.
    drive(0, 1, 1, 3, 16'h7000);
    check("wrap.busy", {15'd0, busy_w}, 16'd1);
    drive(0, 1, 1, 3, 16'h7000);
    drive(0, 1, 1, 3, 16'h8000);
    check_out("sat3", 16'hFFFF, 1, 1, 0);
    check("wrap.res", res_w, 16'h6000);
    check("wrap.rv",  {15'd0, rv_w},  16'd1);
    check("wrap.ovf", {15'd0, ovf_w}, 16'd1);
    drive(0, 1, 0, 3, 16'h0000);

`ifdef ACC_CELL_CLR_IN_EN
    drive(0, 1, 1, 4, 16'h0011);
    drive(0, 1, 1, 4, 16'h0011);
    drive(0, 1, 1, 4, 16'h0011);
    acc_clr = 1'b1;
    drive(0, 1, 0, 4, 16'h0000);
    acc_clr = 1'b0;
    check_out("clr_abort", 16'hFFFF, 0, 1, 0);
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 4, 16'h0000);
      if (rv_s) rv_cnt++;
    end
    check("clr_abort.count", 16'(rv_cnt), 16'd0);
    acc_clr = 1'b1;
    drive(0, 1, 1, 2, 16'h0022);
    acc_clr = 1'b0;
    check_out("clr_first", 16'hFFFF, 0, 1, 0);
    drive(0, 1, 1, 1, 16'h0009);
    check_out("clr_next", 16'h0009, 1, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
